// File: rtl/unary_decoder.sv
// Decodes a unary (thermometer-style) bit stream into a binary count over a fixed
// window of 2^(BIN_BITS+1) cycles, flagging streams that are not one contiguous run.
module unary_decoder #(
    parameter int BIN_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in,
    output logic                busy,
    output logic [BIN_BITS+1:0] count,
    output logic                err,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int U_BITS = 2 ** (BIN_BITS + 1);
    localparam int CNT_W  = BIN_BITS + 2;
    localparam int CYC_W  = BIN_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q,   cyc_d;
    logic [CNT_W-1:0]   acc_q,   acc_d;
    logic               seen_q,  seen_d;
    logic               gap_q,   gap_d;
    logic               bad_q,   bad_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q,   err_d;

    // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        acc_d   = acc_q;
        seen_d  = seen_q;
        gap_d   = gap_q;
        bad_d   = bad_q;
        count_d = count_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // The start cycle is window sample 0.
                    state_d = COUNT;
                    cyc_d   = CYC_W'(1);
                    acc_d   = CNT_W'(in);
                    seen_d  = in;
                    gap_d   = 1'b0;
                    bad_d   = 1'b0;
                end
            end
            COUNT: begin
                if (in) begin
                    acc_d  = acc_q + CNT_W'(1);
                    seen_d = 1'b1;
                    if (gap_q) bad_d = 1'b1;
                end else if (seen_q) begin
                    gap_d = 1'b1;
                end

                if (cyc_q == CYC_W'(U_BITS - 1)) begin
                    state_d = DONE;
                    cyc_d   = '0;
                    count_d = acc_d;
                    err_d   = bad_d;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            acc_q   <= '0;
            seen_q  <= 1'b0;
            gap_q   <= 1'b0;
            bad_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            acc_q   <= acc_d;
            seen_q  <= seen_d;
            gap_q   <= gap_d;
            bad_q   <= bad_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_unary_decoder.sv
// Randomized self-checking bench for unary_decoder; expected results come from a
// population count and first/last-one span of each window.
module tb_unary_decoder;

    localparam int BIN_BITS = 4;
    localparam int U_BITS   = 2 ** (BIN_BITS + 1);
    localparam int CNT_W    = BIN_BITS + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             err;
    logic             out_valid;
    logic             out_ready;

    int checks   = 0;
    int failures = 0;

    unary_decoder #(.BIN_BITS(BIN_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in        (in),
        .busy      (busy),
        .count     (count),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Count is the number of ones; the stream is contiguous iff the span from the
    // first to the last one contains only ones.
    function automatic void model(input logic [U_BITS-1:0] p, output int c, output bit e);
        int first = -1;
        int last  = -1;
        c = $countones(p);
        for (int i = 0; i < U_BITS; i++) begin
            if (p[i]) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        e = (c != 0) && ((last - first + 1) != c);
    endfunction

    // Drives one full window starting in the current cycle, holds the result for
    // `hold` cycles, then completes the handshake with start asserted alongside.
    task automatic run_window(input logic [U_BITS-1:0] p, input int hold);
        int exp_c;
        bit exp_e;
        model(p, exp_c, exp_e);
        @(posedge clk); #1;
        start = 1'b1;
        in    = p[0];
        out_ready = 1'($urandom_range(0, 1));
        for (int i = 1; i < U_BITS; i++) begin
            @(posedge clk); #1;
            start     = ($urandom_range(0, 3) == 0);
            in        = p[i];
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("busy_in_count", busy, 1);
            check("valid_early", out_valid, 0);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        in        = 1'($urandom_range(0, 1));
        out_ready = 1'b0;
        #1;
        check("valid_on_time", out_valid, 1);
        check("count", count, exp_c);
        check("err", err, exp_e);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            in    = 1'($urandom_range(0, 1));
            #1;
            check("valid_hold", out_valid, 1);
            check("count_hold", count, exp_c);
            check("err_hold", err, exp_e);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        #1;
        check("valid_after_hs", out_valid, 0);
        check("busy_after_hs", busy, 0);
        check("count_idle", count, exp_c);
        check("err_idle", err, exp_e);
    endtask

    task automatic random_pattern(output logic [U_BITS-1:0] p);
        int lo, len;
        if ($urandom_range(0, 1) == 0) begin
            lo  = $urandom_range(0, U_BITS - 1);
            len = $urandom_range(0, U_BITS - lo);
            p   = '0;
            for (int i = lo; i < lo + len; i++) p[i] = 1'b1;
        end else begin
            p = U_BITS'({$urandom, $urandom});
        end
    endtask

    initial begin
        logic [U_BITS-1:0] p;
        reset     = 1'b1;
        start     = 1'b0;
        in        = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        reset = 1'b0;

        // First window starts on the first edge with reset low.
        run_window(U_BITS'(32'h0000_007F), 10);
        run_window('0, 0);
        run_window('1, 3);
        run_window(U_BITS'(32'h0000_0C07), 2);

        // Reset in the middle of a window must clear held results and drop the window.
        @(posedge clk); #1;
        start = 1'b1;
        in    = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            in = 1'($urandom_range(0, 1));
            #1;
            check("postrst_valid", out_valid, 0);
            check("postrst_busy", busy, 0);
        end
        run_window(U_BITS'(32'h0000_0FF0), 1);

        for (int n = 0; n < 20; n++) begin
            random_pattern(p);
            run_window(p, $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
